// File: rtl/quet_8led_if.sv
// Bus between the display-code source and the eight-digit scanner:
// scan enable, eight segment codes in, shared segment bus/digit enables/frame pulse out.
interface quet_8led_if;
  logic       en;
  logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic [7:0] seg;
  logic [7:0] dig;
  logic       frame;

  modport master (
    output en, x0, x1, x2, x3, x4, x5, x6, x7,
    input  seg, dig, frame
  );

  modport slave (
    input  en, x0, x1, x2, x3, x4, x5, x6, x7,
    output seg, dig, frame
  );
endinterface

// File: rtl/quet_8led.sv
// Eight-digit multiplexed seven-segment scanner with per-frame snapshot of the codes.
// Optional macro GHOST_BLANK_EN blanks the last BLANK_CYC cycles of every digit slot.
//
// state | meaning
// IDLE  | display dark, cnt/idx parked at 0, snapshot held
// SHOW  | scanning digits 0..7, DIV cycles per digit
module quet_8led #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rstn,
  quet_8led_if.slave bus
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_START = CW'(DIV - BLANK_CYC);
`ifdef GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0][7:0]   snap_q, snap_d;
  logic [7:0]        seg_q, seg_d;
  logic [7:0]        dig_q, dig_d;
  logic              frame_q, frame_d;
  logic [7:0][7:0]   xv;
  logic              drive;

  assign xv = {bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= {8{8'hFF}};
      seg_q   <= 8'hFF;
      dig_q   <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    frame_d = 1'b0;
    seg_d   = 8'hFF;
    dig_d   = 8'hFF;
    drive   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = SHOW;
          snap_d  = xv;
          idx_d   = '0;
          cnt_d   = '0;
          frame_d = 1'b1;
          drive   = 1'b1;
        end
      end
      SHOW: begin
        if (!bus.en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          drive = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            // Frame boundary: take a fresh snapshot so no digit tears mid-frame
            if (idx_q == 3'd7) begin
              snap_d  = xv;
              frame_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are built from next-state so DIG and SEG switch together
    if (drive && !(GHOST && (cnt_d >= BLANK_START))) begin
      dig_d = ~(8'b1 << idx_d);
      seg_d = snap_d[idx_d];
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dig   = dig_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_quet_8led.sv
// Directed bench for quet_8led (DIV=4, BLANK_CYC=1) with a per-cycle expectation queue.
module tb_quet_8led;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME_LEN = 8 * DIV;

  typedef struct packed {
    logic [7:0] dig;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  quet_8led_if bus();

  quet_8led #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         phase  = 0;
  logic [7:0] xs    [8];
  logic [7:0] tsnap [8];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic apply_x();
    bus.x0 = xs[0]; bus.x1 = xs[1]; bus.x2 = xs[2]; bus.x3 = xs[3];
    bus.x4 = xs[4]; bus.x5 = xs[5]; bus.x6 = xs[6]; bus.x7 = xs[7];
  endtask

  task automatic edge_and_check();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk("dig", bus.dig, e.dig);
      chk("seg", bus.seg, e.seg);
      chk("frame", {7'd0, bus.frame}, {7'd0, e.frame});
      checks++;
      assert ($countones(~bus.dig) <= 1) else begin
        errors++;
        $error("FAIL dig_onehot: observed %h expected at most one low bit", bus.dig);
      end
    end
  endtask

  // One enabled clock: expectation comes from the cycle count since enable
  task automatic cyc_on();
    exp_t e;
    int   slot;
    int   pos;
    bus.en = 1'b1;
    apply_x();
    pos = phase % FRAME_LEN;
    if (pos == 0)
      for (int k = 0; k < 8; k++) tsnap[k] = xs[k];
    slot    = pos / DIV;
    e.dig   = ~(8'h01 << slot);
    e.seg   = tsnap[slot];
    e.frame = (pos == 0);
`ifdef GHOST_BLANK_EN
    if ((phase % DIV) >= DIV - BLANK_CYC) begin
      e.dig = 8'hFF;
      e.seg = 8'hFF;
    end
`endif
    sbq.push_back(e);
    edge_and_check();
    phase++;
  endtask

  task automatic cyc_off();
    exp_t e;
    bus.en = 1'b0;
    apply_x();
    e.dig   = 8'hFF;
    e.seg   = 8'hFF;
    e.frame = 1'b0;
    sbq.push_back(e);
    edge_and_check();
    phase = 0;
  endtask

  initial begin
    xs[0] = 8'hFF; xs[1] = 8'hFF; xs[2] = 8'hFF; xs[3] = 8'h89;
    xs[4] = 8'h86; xs[5] = 8'hC7; xs[6] = 8'hC7; xs[7] = 8'hC0;
    for (int k = 0; k < 8; k++) tsnap[k] = 8'hFF;
    bus.en = 1'b1;
    apply_x();

    // Held in reset with EN high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", bus.seg, 8'hFF);
    chk("rst_dig", bus.dig, 8'hFF);
    chk("rst_frame", {7'd0, bus.frame}, 8'h00);
    rstn  = 1'b1;
    phase = 0;

    // HELLO pattern; X4 changes during digit 2 and must only show next frame
    repeat (9) cyc_on();
    xs[4] = 8'h00;
    repeat (55) cyc_on();

    // Drop EN during digit 5, hold 10 cycles, re-enable
    repeat (21) cyc_on();
    repeat (10) cyc_off();
    repeat (40) cyc_on();

    // Run to digit 6 with cnt=2, then async reset mid-slot
    repeat (19) cyc_on();
    #2 rstn = 1'b0;
    #1;
    chk("arst_seg", bus.seg, 8'hFF);
    chk("arst_dig", bus.dig, 8'hFF);
    chk("arst_frame", {7'd0, bus.frame}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("arst_hold_dig", bus.dig, 8'hFF);
    rstn  = 1'b1;
    phase = 0;
    repeat (40) cyc_on();

    chk("sb_drained", 8'(sbq.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
